key_schedule: RTL

- Sequential AES-128 key expansion (FIPS-197) sitting directly upstream of add_round_key.
- Latches a 128-bit cipher key and produces round keys 0..10 one at a time. The current key drives add_round_key's w input.
- The cipher controller advances rounds with a one-cycle next strobe, so only one 128-bit key is stored instead of all 44 words.

---
 rtl/key_schedule.sv | 110 +++++++++++
 1 files changed

// File: rtl/key_schedule.sv
// Sequential AES-128 key expansion: holds one round key and steps it forward on
// each next strobe, feeding add_round_key with the current round key.

module key_schedule_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] b;
      p = 8'h00;
      b = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ b;
         b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] pw;
   logic [7:0] inv;

   // Multiplicative inverse as a^254 (product of a^2..a^128), then the affine map.
   always_comb begin
      pw  = a;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         pw  = gmul(pw, pw);
         inv = gmul(inv, pw);
      end
      y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   input  logic         next,
   output logic [127:0] round_key,
   output logic [3:0]   round,
   output logic         valid,
   output logic         done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [7:0]  rcon;
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, t;
   logic [31:0] n0, n1, n2, n3;

   assign w0  = round_key[127:96];
   assign w1  = round_key[95:64];
   assign w2  = round_key[63:32];
   assign w3  = round_key[31:0];
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sub
      key_schedule_sbox u_sbox (
         .a(rot[8*g +: 8]),
         .y(sub[8*g +: 8])
      );
   end

   assign t  = sub ^ {rcon, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   // start wins over next in any state; done fires only when the last key is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         round_key <= '0;
         round     <= 4'd0;
         valid     <= 1'b0;
         done      <= 1'b0;
         rcon      <= 8'h01;
      end else begin
         done <= 1'b0;
         if (start) begin
            state     <= RUN;
            round_key <= key;
            round     <= 4'd0;
            rcon      <= 8'h01;
            valid     <= 1'b1;
         end else if (state == RUN && next) begin
            if (round == 4'(NR)) begin
               state <= IDLE;
               valid <= 1'b0;
               done  <= 1'b1;
            end else begin
               round_key <= {n0, n1, n2, n3};
               round     <= round + 4'd1;
               rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
         end
      end
   end

endmodule
